// File: rtl/pic8259a_pkg.sv
// Shared definitions for the 8259A interrupt-acknowledge logic: FSM states,
// default pulse/gap lengths and the pulse/gap counter width.
package pic8259a_pkg;

  localparam int unsigned CNT_W         = 4;
  localparam int unsigned PULSE_LEN_DEF = 2;
  localparam int unsigned GAP_LEN_DEF   = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACK1,
    ST_GAP,
    ST_ACK2,
    ST_HOLD
  } inta_state_e;

  // Counter reload value for a phase lasting len cycles (counts down to zero).
  function automatic logic [CNT_W-1:0] len_to_cnt(input int unsigned len);
    return CNT_W'(len - 32'd1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level; synchronous active-low clear.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops to resolve metastability on d.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/inta_sequencer.sv
// Generates the two-pulse INTA handshake towards an 8259A, captures the vector
// byte at the end of the second pulse and holds it until the consumer takes it.
// Optional feature: define INTA_SEQ_SPURIOUS_EN to add the VecSpurious output,
// flagging a vector captured after INT had already dropped.
module inta_sequencer
  import pic8259a_pkg::*;
#(
  parameter int unsigned PULSE_LEN = PULSE_LEN_DEF,
  parameter int unsigned GAP_LEN   = GAP_LEN_DEF
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       INT,
  input  logic       IF_EN,
  input  logic [7:0] DBus,
  output logic       INTA,
  output logic       VecValid,
  output logic [7:0] VecData,
  input  logic       VecReady,
  output logic       Busy
`ifdef INTA_SEQ_SPURIOUS_EN
  ,
  output logic       VecSpurious
`endif
);

  localparam logic [CNT_W-1:0] PULSE_CNT = len_to_cnt(PULSE_LEN);
  localparam logic [CNT_W-1:0] GAP_CNT   = len_to_cnt(GAP_LEN);

  inta_state_e      state;
  inta_state_e      state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             int_s;
  logic             capture;

  sync_2ff u_int_sync (
    .clk   (CLK),
    .rst_n (RST_N),
    .d     (INT),
    .q     (int_s)
  );

  // Next-state and counter: each phase reloads the counter on entry and leaves at zero.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    unique case (state)
      ST_IDLE: begin
        if (int_s && IF_EN) begin
          state_next = ST_ACK1;
          cnt_next   = PULSE_CNT;
        end
      end
      ST_ACK1: begin
        if (cnt == '0) begin
          state_next = ST_GAP;
          cnt_next   = GAP_CNT;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (cnt == '0) begin
          state_next = ST_ACK2;
          cnt_next   = PULSE_CNT;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      ST_ACK2: begin
        if (cnt == '0) begin
          state_next = ST_HOLD;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (VecReady) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  assign capture = (state == ST_ACK2) && (state_next == ST_HOLD);

  // State register; outputs decoded from the next state so they align with it.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      INTA     <= 1'b1;
      VecValid <= 1'b0;
      VecData  <= 8'h00;
      Busy     <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      INTA     <= !((state_next == ST_ACK1) || (state_next == ST_ACK2));
      VecValid <= (state_next == ST_HOLD);
      Busy     <= (state_next != ST_IDLE);
      if (capture) begin
        VecData <= DBus;
      end
    end
  end

`ifdef INTA_SEQ_SPURIOUS_EN
  // Spurious flag: INT already gone when the vector byte was latched.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      VecSpurious <= 1'b0;
    end else if (capture) begin
      VecSpurious <= !int_s;
    end
  end
`endif

endmodule

// File: tb/tb_inta_sequencer.sv
// Self-checking bench for inta_sequencer: cycle-by-cycle INTA/Busy/VecValid
// checks plus a vector scoreboard per instance.
module tb_inta_sequencer;

  logic       CLK;
  logic       RST_N;
  logic       INT;
  logic       int2;
  logic       IF_EN;
  logic [7:0] DBus;
  logic       VecReady;

  logic       INTA,  inta2;
  logic       VecValid, valid2;
  logic [7:0] VecData, data2;
  logic       Busy, busy2;
`ifdef INTA_SEQ_SPURIOUS_EN
  logic       VecSpurious, spur2;
`endif

  int n_vec = 0;
  int n_err = 0;

  logic [8:0] exp_q[$];
  logic [8:0] exp2_q[$];

  inta_sequencer u_dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .INT      (INT),
    .IF_EN    (IF_EN),
    .DBus     (DBus),
    .INTA     (INTA),
    .VecValid (VecValid),
    .VecData  (VecData),
    .VecReady (VecReady),
    .Busy     (Busy)
`ifdef INTA_SEQ_SPURIOUS_EN
    ,
    .VecSpurious (VecSpurious)
`endif
  );

  inta_sequencer #(.PULSE_LEN(1), .GAP_LEN(3)) u_p13 (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .INT      (int2),
    .IF_EN    (IF_EN),
    .DBus     (DBus),
    .INTA     (inta2),
    .VecValid (valid2),
    .VecData  (data2),
    .VecReady (VecReady),
    .Busy     (busy2)
`ifdef INTA_SEQ_SPURIOUS_EN
    ,
    .VecSpurious (spur2)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Reference: o is the offset from the first INTA-low cycle (negative = before it).
  function automatic logic exp_inta(input int o, input int p, input int g);
    return !((o >= 0 && o < p) || (o >= p + g && o < 2 * p + g));
  endfunction

  task automatic check_cycle(input string tag, input int o, input int p, input int g,
                             input logic inta, input logic valid, input logic busy);
    check({tag, "_inta"},  32'(inta),  32'(exp_inta(o, p, g)));
    check({tag, "_valid"}, 32'(valid), 32'(o == 2 * p + g));
    check({tag, "_busy"},  32'(busy),  32'(o >= 0 && o <= 2 * p + g));
  endtask

  // Scoreboard: a transfer happens at the edge following a cycle with VecValid and VecReady.
  always @(negedge CLK) begin
    logic [8:0] e;
    if (RST_N && VecValid && VecReady) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected", 32'(1), 32'(0));
      end else begin
        e = exp_q.pop_front();
        check("vec_data", 32'(VecData), 32'(e[7:0]));
`ifdef INTA_SEQ_SPURIOUS_EN
        check("vec_spur", 32'(VecSpurious), 32'(e[8]));
`endif
      end
    end
    if (RST_N && valid2 && VecReady) begin
      if (exp2_q.size() == 0) begin
        check("sb2_unexpected", 32'(1), 32'(0));
      end else begin
        e = exp2_q.pop_front();
        check("p13_data", 32'(data2), 32'(e[7:0]));
`ifdef INTA_SEQ_SPURIOUS_EN
        check("p13_spur", 32'(spur2), 32'(e[8]));
`endif
      end
    end
  end

  initial begin
    RST_N = 1'b0; INT = 1'b0; int2 = 1'b0; IF_EN = 1'b0; DBus = 8'h00; VecReady = 1'b0;
    repeat (3) tick();
    check("rst_inta",  32'(INTA),     32'(1));
    check("rst_valid", 32'(VecValid), 32'(0));
    check("rst_data",  32'(VecData),  32'(0));
    check("rst_busy",  32'(Busy),     32'(0));
    check("rst2_inta", 32'(inta2),    32'(1));
    RST_N = 1'b1;
    repeat (2) tick();

    // Basic sequence: INT rises before edge 0, first INTA low in cycle 3.
    IF_EN = 1'b1; DBus = 8'h92; VecReady = 1'b1; INT = 1'b1;
    exp_q.push_back({1'b0, 8'h92});
    for (int c = 1; c <= 10; c++) begin
      tick();
      check_cycle("basic", c - 3, 2, 2, INTA, VecValid, Busy);
      if (c == 8) INT = 1'b0;
    end
    repeat (4) tick();

    // Backpressure, VecReady ignored outside HOLD, and restart spacing after transfer.
    INT = 1'b1; DBus = 8'h92; VecReady = 1'b0;
    exp_q.push_back({1'b0, 8'h92});
    for (int c = 1; c <= 14; c++) begin
      tick();
      if (c <= 8) begin
        check_cycle("bp", c - 3, 2, 2, INTA, VecValid, Busy);
      end else begin
        check("bp_hold_valid", 32'(VecValid), 32'(1));
        check("bp_hold_data",  32'(VecData),  32'(8'h92));
        check("bp_hold_inta",  32'(INTA),     32'(1));
        check("bp_hold_busy",  32'(Busy),     32'(1));
      end
      VecReady = (c >= 3 && c <= 8) || (c == 14);
      if (c >= 9) DBus = 8'h55;
    end
    tick();
    check("bp_idle_valid", 32'(VecValid), 32'(0));
    check("bp_idle_busy",  32'(Busy),     32'(0));
    check("bp_idle_inta",  32'(INTA),     32'(1));
    DBus = 8'h5A;
    tick();
    check("bp_restart", 32'(INTA), 32'(0));
    INT = 1'b0;
    exp_q.push_back({1'b1, 8'h5A});
    for (int o = 0; o <= 7; o++) begin
      if (o > 0) tick();
      check_cycle("bp2", o, 2, 2, INTA, VecValid, Busy);
    end
    repeat (4) tick();

    // Masked: INT high with IF_EN low, then IF_EN releases the sequence one cycle later.
    INT = 1'b1; IF_EN = 1'b0; DBus = 8'h33;
    for (int c = 0; c < 20; c++) begin
      tick();
      check("mask_inta", 32'(INTA), 32'(1));
      check("mask_busy", 32'(Busy), 32'(0));
    end
    IF_EN = 1'b1;
    exp_q.push_back({1'b0, 8'h33});
    for (int o = 0; o <= 7; o++) begin
      tick();
      check_cycle("mask", o, 2, 2, INTA, VecValid, Busy);
      if (o == 5) INT = 1'b0;
    end
    repeat (4) tick();

    // Mid-sequence drop of IF_EN and INT during GAP: sequence still completes.
    INT = 1'b1; IF_EN = 1'b1; DBus = 8'h97;
    exp_q.push_back({1'b1, 8'h97});
    for (int c = 1; c <= 10; c++) begin
      tick();
      check_cycle("mid", c - 3, 2, 2, INTA, VecValid, Busy);
      if (c == 5) begin
        IF_EN = 1'b0;
        INT   = 1'b0;
      end
    end
    IF_EN = 1'b1;
    repeat (4) tick();

    // Reset asserted during the first ACK2 cycle.
    INT = 1'b1; DBus = 8'h11;
    for (int c = 1; c <= 7; c++) begin
      tick();
      check_cycle("rstmid", c - 3, 2, 2, INTA, VecValid, Busy);
    end
    RST_N = 1'b0; INT = 1'b0;
    tick();
    check("rstmid_inta",  32'(INTA),     32'(1));
    check("rstmid_valid", 32'(VecValid), 32'(0));
    check("rstmid_busy",  32'(Busy),     32'(0));
    RST_N = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      check("rstmid_quiet_inta",  32'(INTA),     32'(1));
      check("rstmid_quiet_valid", 32'(VecValid), 32'(0));
    end

    // PULSE_LEN=1, GAP_LEN=3 instance.
    int2 = 1'b1; DBus = 8'h6C; VecReady = 1'b1;
    exp2_q.push_back({1'b0, 8'h6C});
    for (int c = 1; c <= 9; c++) begin
      tick();
      check_cycle("p13", c - 3, 1, 3, inta2, valid2, busy2);
      check("p13_main_idle", 32'(Busy), 32'(0));
      if (c == 6) int2 = 1'b0;
    end
    repeat (4) tick();

    check("sb_left",  32'(exp_q.size()),  32'(0));
    check("sb2_left", 32'(exp2_q.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
